// File: rtl/stream_demultiplexer.sv
// Routes each input word to one of NUM_OUTPUTS single-entry output slots,
// chosen by the highest set bit of a one-hot select; zero selects are counted and dropped.
module stream_demultiplexer #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_OUTPUTS = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_OUTPUTS-1:0]            in_sel,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic [NUM_OUTPUTS-1:0]            out_valid,
  input  logic [NUM_OUTPUTS-1:0]            out_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
  output logic [7:0]                        err_count
);

  // Handshake: a word moves on any rising edge where valid and ready are both high;
  // the producer holds valid, select and data stable until that edge.

  logic [NUM_OUTPUTS-1:0]            valid_q, valid_d;
  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] data_q, data_d;
  logic [7:0]                        err_count_q, err_count_d;
  logic [NUM_OUTPUTS-1:0]            dest_oh;
  logic [NUM_OUTPUTS-1:0]            load;
  logic                              sel_none;
  logic                              accept;

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    dest_oh = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (in_sel[i]) begin
        dest_oh    = '0;
        dest_oh[i] = 1'b1;
      end
    end
  end

  assign sel_none = ~|in_sel;

  // Only the destination slot can stall the input; a zero select never stalls.
  assign in_ready = rst_n & ~|(dest_oh & valid_q & ~out_ready);
  assign accept   = in_valid & in_ready;
  assign load     = accept ? dest_oh : '0;

  always_comb begin
    valid_d     = (valid_q & ~out_ready) | load;
    data_d      = data_q;
    err_count_d = err_count_q;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (load[i]) begin
        data_d[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end
    end
    if (accept && sel_none && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      data_q      <= '0;
      err_count_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign err_count = err_count_q;

endmodule
